// File: rtl/target_entry_parser_if.sv
// Keyboard-entry bus: character stream in, committed targets and echo writes out.
interface target_entry_parser_if;
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned COORD_W = 32;

  logic               char_valid;
  logic [CHAR_W-1:0]  char_in;
  logic [COORD_W-1:0] targetx;
  logic [COORD_W-1:0] targety;
  logic               target_valid;
  logic               error;
  logic               echo_we;
  logic [CHAR_W-1:0]  echo_index;
  logic [CHAR_W-1:0]  echo_data;
  logic               line_active;

  modport master (
    output char_valid, char_in,
    input  targetx, targety, target_valid, error,
    input  echo_we, echo_index, echo_data, line_active
  );

  modport slave (
    input  char_valid, char_in,
    output targetx, targety, target_valid, error,
    output echo_we, echo_index, echo_data, line_active
  );
endinterface

// File: rtl/target_entry_parser.sv
// Parses a typed "XXXX,YYYY<Enter>" line into digit-nibble target coordinates.
// Optional backspace editing is enabled by defining TARGET_ENTRY_BACKSPACE_EN.
module target_entry_parser #(
  parameter logic [7:0] ECHO_BASE  = 8'd148,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input logic                  clock,
  input logic                  reset,
  target_entry_parser_if.slave bus
);
  localparam int unsigned POS_W   = 4;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned COORD_W = 32;
  localparam logic [CHAR_W-1:0] BS_CHAR = 8'h08;

  typedef enum logic [1:0] {S_X, S_SEP, S_Y, S_ENT} state_t;

  state_t                   state_q, state_d;
  logic [POS_W-1:0]         pos_q, pos_d;
  logic [3:0][DIG_W-1:0]    x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]       targetx_q, targetx_d, targety_q, targety_d;
  logic                     target_valid_q, target_valid_d;
  logic                     error_q, error_d;
  logic                     echo_we_q, echo_we_d;
  logic [CHAR_W-1:0]        echo_index_q, echo_index_d;
  logic [CHAR_W-1:0]        echo_data_q, echo_data_d;

  logic             is_digit, is_sep, is_enter, bs_hit;
  logic [DIG_W-1:0] digit;
  logic [POS_W-1:0] pos_m1;

  assign is_digit = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
  assign is_sep   = (bus.char_in == 8'h2C) || (bus.char_in == 8'h20);
  assign is_enter = (bus.char_in == 8'h0D) || (bus.char_in == 8'h0A);
  assign digit    = DIG_W'(bus.char_in - 8'h30);
  assign pos_m1   = pos_q - 4'd1;

`ifdef TARGET_ENTRY_BACKSPACE_EN
  assign bs_hit = (bus.char_in == BS_CHAR);
`else
  assign bs_hit = 1'b0;
`endif

  // Field state is a pure function of cursor position.
  function automatic state_t state_of(input logic [POS_W-1:0] p);
    if (p <= 4'd3)       return S_X;
    else if (p == 4'd4)  return S_SEP;
    else if (p <= 4'd8)  return S_Y;
    else                 return S_ENT;
  endfunction

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    x_d            = x_q;
    y_d            = y_q;
    targetx_d      = targetx_q;
    targety_d      = targety_q;
    target_valid_d = 1'b0;
    error_d        = 1'b0;
    echo_we_d      = 1'b0;
    echo_index_d   = echo_index_q;
    echo_data_d    = echo_data_q;

    if (bus.char_valid) begin
      if (bs_hit) begin
        // Backspace at pos 0 is silently ignored.
        if (pos_q != '0) begin
          pos_d        = pos_m1;
          state_d      = state_of(pos_m1);
          echo_we_d    = 1'b1;
          echo_index_d = ECHO_BASE + CHAR_W'(pos_m1);
          echo_data_d  = BLANK_CHAR;
          if (pos_m1 <= 4'd3)
            x_d[2'(4'd3 - pos_m1)] = '0;
          else if (pos_m1 >= 4'd5 && pos_m1 <= 4'd8)
            y_d[2'(4'd8 - pos_m1)] = '0;
        end
      end else begin
        error_d = 1'b1;
        unique case (state_q)
          S_X: if (is_digit) begin
            error_d                = 1'b0;
            x_d[2'(4'd3 - pos_q)]  = digit;
            pos_d                  = pos_q + 4'd1;
            state_d                = (pos_q == 4'd3) ? S_SEP : S_X;
          end
          S_SEP: if (is_sep) begin
            error_d = 1'b0;
            pos_d   = 4'd5;
            state_d = S_Y;
          end
          S_Y: if (is_digit) begin
            error_d                = 1'b0;
            y_d[2'(4'd8 - pos_q)]  = digit;
            pos_d                  = pos_q + 4'd1;
            state_d                = (pos_q == 4'd8) ? S_ENT : S_Y;
          end
          S_ENT: if (is_enter) begin
            error_d        = 1'b0;
            targetx_d      = {4'h0, x_q[3], 4'h0, x_q[2], 4'h0, x_q[1], 4'h0, x_q[0]};
            targety_d      = {4'h0, y_q[3], 4'h0, y_q[2], 4'h0, y_q[1], 4'h0, y_q[0]};
            target_valid_d = 1'b1;
            x_d            = '0;
            y_d            = '0;
            pos_d          = '0;
            state_d        = S_X;
          end
          default: ;
        endcase

        // Accepted digits and separators echo at the pre-increment position.
        if (!error_d && state_q != S_ENT) begin
          echo_we_d    = 1'b1;
          echo_index_d = ECHO_BASE + CHAR_W'(pos_q);
          echo_data_d  = bus.char_in;
        end

        if (error_d) begin
          x_d     = '0;
          y_d     = '0;
          pos_d   = '0;
          state_d = S_X;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_X;
      pos_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      targetx_q      <= '0;
      targety_q      <= '0;
      target_valid_q <= 1'b0;
      error_q        <= 1'b0;
      echo_we_q      <= 1'b0;
      echo_index_q   <= '0;
      echo_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      x_q            <= x_d;
      y_q            <= y_d;
      targetx_q      <= targetx_d;
      targety_q      <= targety_d;
      target_valid_q <= target_valid_d;
      error_q        <= error_d;
      echo_we_q      <= echo_we_d;
      echo_index_q   <= echo_index_d;
      echo_data_q    <= echo_data_d;
    end
  end

  assign bus.targetx      = targetx_q;
  assign bus.targety      = targety_q;
  assign bus.target_valid = target_valid_q;
  assign bus.error        = error_q;
  assign bus.echo_we      = echo_we_q;
  assign bus.echo_index   = echo_index_q;
  assign bus.echo_data    = echo_data_q;
  assign bus.line_active  = (pos_q != '0);
endmodule

// File: tb/tb_target_entry_parser.sv
// Directed vector bench for target_entry_parser (table plus reset/backspace sequences).
module tb_target_entry_parser;
  logic clock;
  logic reset;

  target_entry_parser_if bus_if ();

  target_entry_parser dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [7:0]  ch;
    logic        tv;
    logic        err;
    logic        we;
    logic [7:0]  idx;
    logic [7:0]  data;
    logic        la;
    logic [31:0] tx;
    logic [31:0] ty;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_tx;
  logic [31:0] exp_ty;
  int          errors;
  int          checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic v, input logic [7:0] c, input logic tv,
                               input logic er, input logic we, input logic [7:0] idx,
                               input logic [7:0] data, input logic la);
    vec_t r;
    r.valid = v; r.ch = c; r.tv = tv; r.err = er; r.we = we;
    r.idx = idx; r.data = data; r.la = la; r.tx = exp_tx; r.ty = exp_ty;
    vecs.push_back(r);
  endfunction

  // Accepted characters starting at cursor position p0, with gap idle cycles after each.
  function automatic void add_line(input string s, input int p0, input int gap);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      push(1'b1, c, 1'b0, 1'b0, 1'b1, 8'(148 + p0 + i), c, 1'b1);
      for (int g = 0; g < gap; g++) push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    end
  endfunction

  function automatic void add_idle(input logic la);
    push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, la);
  endfunction

  function automatic void add_reject(input logic [7:0] c);
    push(1'b1, c, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    add_idle(1'b0);
  endfunction

  function automatic void add_commit(input logic [7:0] c, input logic [31:0] tx, input logic [31:0] ty);
    exp_tx = tx;
    exp_ty = ty;
    push(1'b1, c, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    add_idle(1'b0);
  endfunction

  task automatic send(input logic [7:0] c);
    bus_if.char_valid = 1'b1;
    bus_if.char_in    = c;
    @(posedge clock); #1;
    bus_if.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic check_outputs(input string tag, input logic tv, input logic er,
                               input logic we, input logic la);
    check({tag, " target_valid"}, 32'(bus_if.target_valid), 32'(tv));
    check({tag, " error"},        32'(bus_if.error),        32'(er));
    check({tag, " echo_we"},      32'(bus_if.echo_we),      32'(we));
    check({tag, " line_active"},  32'(bus_if.line_active),  32'(la));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_tx = '0;
    exp_ty = '0;
    reset  = 1'b1;
    bus_if.char_valid = 1'b0;
    bus_if.char_in    = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset targetx", bus_if.targetx, 32'h0);
    check("reset targety", bus_if.targety, 32'h0);
    reset = 1'b0;

    // Slow-paced full line, then commit.
    add_line("1234,5678", 0, 2);
    add_commit(8'h0D, 32'h01020304, 32'h05060708);
    // Bad character mid-line, then recovery with space separator and LF.
    add_line("12", 0, 0);
    add_reject("a");
    add_line("0009 0001", 0, 0);
    add_commit(8'h0A, 32'h00000009, 32'h00000001);
    // Early Enter.
    add_line("123", 0, 0);
    add_reject(8'h0D);
    // Back-to-back line.
    add_line("9876,5432", 0, 0);
    add_commit(8'h0D, 32'h09080706, 32'h05040302);
    // Digit where separator expected, digit where Enter expected, comma first.
    add_line("1234", 0, 0);
    add_reject("5");
    add_line("1234,5678", 0, 0);
    add_reject("9");
    add_reject(",");

    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.char_valid = vecs[i].valid;
      bus_if.char_in    = vecs[i].ch;
      @(posedge clock); #1;
      check($sformatf("vec%0d target_valid", i), 32'(bus_if.target_valid), 32'(vecs[i].tv));
      check($sformatf("vec%0d error", i),        32'(bus_if.error),        32'(vecs[i].err));
      check($sformatf("vec%0d echo_we", i),      32'(bus_if.echo_we),      32'(vecs[i].we));
      check($sformatf("vec%0d line_active", i),  32'(bus_if.line_active),  32'(vecs[i].la));
      check($sformatf("vec%0d targetx", i),      bus_if.targetx,           vecs[i].tx);
      check($sformatf("vec%0d targety", i),      bus_if.targety,           vecs[i].ty);
      if (vecs[i].we) begin
        check($sformatf("vec%0d echo_index", i), 32'(bus_if.echo_index), 32'(vecs[i].idx));
        check($sformatf("vec%0d echo_data", i),  32'(bus_if.echo_data),  32'(vecs[i].data));
      end
    end
    bus_if.char_valid = 1'b0;

    // Reset in the middle of a line discards it and clears committed targets.
    send_str("1234,56");
    check("pre-reset line_active", 32'(bus_if.line_active), 32'h1);
    reset = 1'b1;
    #1;
    check_outputs("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("async reset targetx", bus_if.targetx, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_outputs("after reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("after reset targety", bus_if.targety, 32'h0);
    check("after reset echo_index", 32'(bus_if.echo_index), 32'h0);
    send_str("1111,2222");
    send(8'h0D);
    check_outputs("post-reset commit", 1'b1, 1'b0, 1'b0, 1'b0);
    check("post-reset targetx", bus_if.targetx, 32'h01010101);
    check("post-reset targety", bus_if.targety, 32'h02020202);

`ifdef TARGET_ENTRY_BACKSPACE_EN
    send_str("12");
    send(8'h08);
    check_outputs("bs mid", 1'b0, 1'b0, 1'b1, 1'b1);
    check("bs echo_index", 32'(bus_if.echo_index), 32'd149);
    check("bs echo_data",  32'(bus_if.echo_data),  32'h20);
    send_str("345,0000");
    check("bs resumed echo_index", 32'(bus_if.echo_index), 32'd156);
    send(8'h0D);
    check_outputs("bs commit", 1'b1, 1'b0, 1'b0, 1'b0);
    check("bs targetx", bus_if.targetx, 32'h01030405);
    check("bs targety", bus_if.targety, 32'h00000000);
    send(8'h08);
    check_outputs("bs at pos0", 1'b0, 1'b0, 1'b0, 1'b0);
    // Backspace from the Enter position back into Y, retype last digit.
    send_str("1111,2222");
    send(8'h08);
    check("bs from ent echo_index", 32'(bus_if.echo_index), 32'd156);
    send("7");
    send(8'h0D);
    check("bs retype targety", bus_if.targety, 32'h02020207);
`else
    send_str("12");
    send(8'h08);
    check_outputs("bs illegal", 1'b0, 1'b1, 1'b0, 1'b0);
    check("bs illegal targetx", bus_if.targetx, 32'h01010101);
    send(8'h0D);
    check_outputs("bs discarded", 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
